event_encoder_8to3: RTL and testbench

EVENT_ENCODER_8TO3 -- requirements
Module: event_encoder_8to3

---
 rtl/event_enc_pkg.sv | 16 +
 rtl/prio_pick8.sv | 35 +++
 rtl/event_encoder_8to3.sv | 103 ++++++++++
 tb/tb_event_encoder_8to3.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/event_enc_pkg.sv
// Shared constants and types for the 8-to-3 event encoder.
// Round-robin selection is enabled by defining EVENT_ENCODER_ROUND_ROBIN_EN.
package event_enc_pkg;

    localparam int NUM_EVENTS = 8;
    localparam int CODE_W     = 3;

    typedef logic [CODE_W-1:0] code_t;

    function automatic logic [NUM_EVENTS-1:0] code_onehot(input code_t c);
        logic [NUM_EVENTS-1:0] one;
        one = 8'h01;
        return one << c;
    endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational 8-way picker: first set bit of pending, searching from start
// upward (wrapping) or, with REVERSE set, downward (wrapping).
module prio_pick8
    import event_enc_pkg::*;
#(
    parameter bit REVERSE = 1'b1
) (
    input  logic [NUM_EVENTS-1:0] pending,
    input  code_t                 start,
    output code_t                 idx,
    output logic                  found
);

    // Scan all eight positions in search order and keep the first hit.
    always_comb begin
        code_t w_pos;
        idx   = 3'd0;
        found = 1'b0;
        w_pos = 3'd0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (REVERSE) begin
                w_pos = start - code_t'(k);
            end else begin
                w_pos = start + code_t'(k);
            end
            if (!found && pending[w_pos]) begin
                idx   = w_pos;
                found = 1'b1;
            end else begin
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/event_encoder_8to3.sv
// Captures event lines into a pending set and issues one index per handshake.
// Define EVENT_ENCODER_ROUND_ROBIN_EN for round-robin instead of highest-first.
module event_encoder_8to3
    import event_enc_pkg::*;
#(
    parameter code_t IDLE_CODE = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_EVENTS-1:0] req,
    output code_t                 code,
    output logic                  valid,
    input  logic                  ready,
    output logic [NUM_EVENTS-1:0] pending,
    output logic                  ovf
);

    logic [NUM_EVENTS-1:0] r_pending;
    logic                  r_valid;
    code_t                 r_code;
    logic                  r_ovf;

    code_t                 w_start;
    code_t                 w_idx;
    logic                  w_found;
    logic                  w_slot_free;
    logic                  w_load;
    logic [NUM_EVENTS-1:0] w_clear;
    logic [NUM_EVENTS-1:0] w_capture;
    logic [NUM_EVENTS-1:0] w_held;
    logic [NUM_EVENTS-1:0] w_merge;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    code_t r_ptr;

    assign w_start = r_ptr + 3'd1;

    prio_pick8 #(.REVERSE(1'b0)) u_pick (
        .pending (r_pending),
        .start   (w_start),
        .idx     (w_idx),
        .found   (w_found)
    );

    // Last issued index; moves only when a new event is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 3'd0;
        end else if (w_load) begin
            r_ptr <= w_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    assign w_start = 3'd7;

    prio_pick8 #(.REVERSE(1'b1)) u_pick (
        .pending (r_pending),
        .start   (w_start),
        .idx     (w_idx),
        .found   (w_found)
    );
`endif

    assign w_slot_free = !r_valid || ready;
    assign w_load      = w_slot_free && w_found;
    assign w_clear     = w_load  ? code_onehot(w_idx)  : 8'h00;
    assign w_capture   = en      ? req                 : 8'h00;
    // The index sitting in code is not counted as a lost event.
    assign w_held      = r_valid ? code_onehot(r_code) : 8'h00;
    assign w_merge     = w_capture & r_pending & ~w_clear & ~w_held;

    // Pending set, output slot and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= 8'h00;
            r_valid   <= 1'b0;
            r_code    <= IDLE_CODE;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_capture;
            r_ovf     <= r_ovf | (|w_merge);
            if (w_load) begin
                r_valid <= 1'b1;
                r_code  <= w_idx;
            end else if (w_slot_free) begin
                r_valid <= 1'b0;
                r_code  <= IDLE_CODE;
            end else begin
                r_valid <= r_valid;
                r_code  <= r_code;
            end
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Scoreboard bench for event_encoder_8to3: directed scenarios then random traffic.
module tb_event_encoder_8to3;
    import event_enc_pkg::*;

    localparam code_t IDLE = 3'b000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] req   = 8'h00;
    code_t      code;
    logic       valid;
    logic       ovf;
    logic [7:0] pending;

    always #5 clk = ~clk;

    event_encoder_8to3 #(.IDLE_CODE(IDLE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .ovf     (ovf)
    );

    int    errors = 0;
    int    checks = 0;
    code_t exp_q[$];

    // Reference model: a set of pending events and the output slot contents.
    bit m_pend [8];
    bit m_valid = 1'b0;
    int m_code  = 0;
    bit m_ovf   = 1'b0;
    int m_last  = 0;

    function automatic int choose();
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        for (int d = 1; d <= 8; d++) begin
            if (m_pend[(m_last + d) % 8]) return (m_last + d) % 8;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (m_pend[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [7:0] pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_edge();
        int pick;
        bit old_v;
        int old_c;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_code  = int'(IDLE);
            m_ovf   = 1'b0;
            m_last  = 0;
            exp_q.delete();
            return;
        end
        old_v = m_valid;
        old_c = m_code;
        if (!m_valid || ready) begin
            pick = choose();
            if (pick >= 0) begin
                m_valid      = 1'b1;
                m_code       = pick;
                m_last       = pick;
                m_pend[pick] = 1'b0;
                exp_q.push_back(code_t'(pick));
            end else begin
                m_valid = 1'b0;
                m_code  = int'(IDLE);
            end
        end
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) begin
                    if (m_pend[i] && !(old_v && old_c == i)) m_ovf = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input logic [7:0] q, input bit rd);
        rst_n = r;
        en    = e;
        req   = q;
        ready = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: status against the model, issued codes against the scoreboard queue.
    always @(negedge clk) begin
        chk("valid",   int'(valid),   int'(m_valid));
        chk("pending", int'(pending), int'(pend_vec()));
        chk("ovf",     int'(ovf),     int'(m_ovf));
        if (!valid) chk("idle_code", int'(code), int'(IDLE));
        else        chk("held_code", int'(code), m_code);
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handshake: got code %0d expected no issue at %0t", code, $time);
            end else begin
                chk("issued_code", int'(code), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        // Reset with every line requesting.
        repeat (3) cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        // Single event.
        cyc(1'b1, 1'b1, 8'h20, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        // Burst.
        cyc(1'b1, 1'b1, 8'h8A, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        // Backpressure.
        cyc(1'b1, 1'b1, 8'h0C, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        // Overflow by merging behind a stalled code=4, then re-request of 4.
        cyc(1'b1, 1'b1, 8'h10, 1'b0);
        cyc(1'b1, 1'b1, 8'h01, 1'b0);
        cyc(1'b1, 1'b1, 8'h01, 1'b0);
        cyc(1'b1, 1'b1, 8'h10, 1'b0);
        repeat (6) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        // Enable gating, then reset with an event in flight.
        cyc(1'b1, 1'b1, 8'h01, 1'b0);
        cyc(1'b1, 1'b1, 8'h30, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 8'hFF, 1'b0);
        cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                8'($urandom & $urandom), ($urandom_range(0, 2) != 0));
        end
        // Drain.
        repeat (20) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("drained_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
